// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: shared FSM state type and read-buffer sizing for the burst master
package mem_burst_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD, RD_DRAIN} state_e;
  localparam int RD_BUF_DEPTH = 2;
endpackage

// File: rtl/rd_skid_fifo.sv
// rd_skid_fifo: 2-entry FIFO that catches read data still in flight from the storage unit
module rd_skid_fifo
  import mem_burst_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       occ_o
);
  logic [WIDTH-1:0] mem_q [RD_BUF_DEPTH];
  logic             wp_q, rp_q;
  logic [1:0]       occ_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= data_i;
        wp_q        <= ~wp_q;
      end
      if (pop_i) rp_q <= ~rp_q;
      occ_q <= occ_q + 2'(push_i) - 2'(pop_i);
    end
  end
  assign data_o = mem_q[rp_q];
  assign occ_o  = occ_q;
endmodule

// File: rtl/mem_burst_master.sv
// mem_burst_master: read/write burst initiator driving one flip-flop storage unit
module mem_burst_master
  import mem_burst_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LEN_W = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_data_in,
  output logic             mem_write_en,
  output logic             mem_read_en,
  input  logic [WIDTH-1:0] mem_data_out,
  output logic             busy,
  output logic             done
);
  state_e           state_q;
  logic [AW-1:0]    addr_q, addr_inc;
  logic [LEN_W-1:0] remain_q;
  logic             pend_q, done_q;
  logic [1:0]       occ;
  logic             pop, issue, wr_acc, last;
  assign pop      = rd_valid && rd_ready;
  assign wr_acc   = state_q == WR && wr_valid;
  // credit: words buffered plus the one in flight, after this cycle's pop, must leave room
  assign issue    = state_q == RD && remain_q != '0 && ({1'b0, occ} + 3'(pend_q)) < 3'd2 + 3'(pop);
  assign last     = remain_q == LEN_W'(1);
  assign addr_inc = addr_q == AW'(DEPTH - 1) ? '0 : addr_q + AW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pend_q <= issue;
      if (wr_acc || issue) begin
        addr_q   <= addr_inc;
        remain_q <= remain_q - LEN_W'(1);
      end
      case (state_q)
        IDLE: if (cmd_valid) begin
          addr_q   <= cmd_addr;
          remain_q <= cmd_len;
          if (cmd_len == '0) done_q <= 1'b1;
          else state_q <= cmd_write ? WR : RD;
        end
        WR: if (wr_acc && last) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        RD: if (issue && last) state_q <= RD_DRAIN;
        RD_DRAIN: if (!pend_q && occ == 2'd1 && pop) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      endcase
    end
  end
  rd_skid_fifo #(.WIDTH(WIDTH)) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (pend_q),
    .pop_i  (pop),
    .data_i (mem_data_out),
    .data_o (rd_data),
    .occ_o  (occ)
  );
  assign cmd_ready    = state_q == IDLE;
  assign busy         = state_q != IDLE;
  assign wr_ready     = state_q == WR;
  assign mem_write_en = wr_acc;
  assign mem_read_en  = issue;
  assign mem_addr     = addr_q;
  assign mem_data_in  = wr_ready ? wr_data : '0;
  assign rd_valid     = occ != 2'd0;
  assign done         = done_q;
endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master: random and directed bursts against a transaction-level model
module tb_mem_burst_master;
  localparam int WIDTH = 8, DEPTH = 16, AW = 4, LEN_W = 5;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic wr_valid = 0, wr_ready, rd_valid, rd_ready = 0;
  logic [WIDTH-1:0] wr_data = '0, rd_data, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_addr;
  logic mem_write_en, mem_read_en, busy, done;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mem_burst_master #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_data_out(mem_data_out), .busy(busy), .done(done)
  );

  // storage unit: registered read, write at clock edge
  logic [WIDTH-1:0] smem [DEPTH];
  always @(posedge clk) begin
    if (mem_write_en) smem[mem_addr] <= mem_data_in;
    if (mem_read_en) mem_data_out <= smem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model state (written only by the monitor)
  logic [WIDTH-1:0] refmem [DEPTH];
  logic [WIDTH-1:0] wbuf [32];
  logic [WIDTH-1:0] exp_rdata [$];
  int m_mode = 0, w_addr, w_len, w_idx, r_addr, r_len, r_issued, r_popped;
  bit last_issue = 0, done_exp = 0;
  int cyc_n = 0, acc_cyc = 0, first_rv = -1, dn_cnt = 0, en_cnt = 0, max_out = 0;
  int wlog_a [$], wlog_c [$], rlog_d [$], rlog_c [$];

  always @(negedge clk) begin : mon
    logic pop;
    int outst;
    cyc_n++;
    if (!rst_n) begin
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data_in", mem_data_in, 0);
      chk("rst_mem_we", mem_write_en, 0);
      chk("rst_mem_re", mem_read_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      m_mode = 0; done_exp = 0; last_issue = 0;
      exp_rdata.delete();
    end else begin
      pop = rd_valid && rd_ready;
      if (done) dn_cnt++;
      if (mem_write_en || mem_read_en) en_cnt++;
      chk("done", done, done_exp);
      done_exp = 0;
      chk("busy", busy, m_mode != 0);
      chk("cmd_ready", cmd_ready, m_mode == 0);
      if (m_mode == 0) begin
        chk("idle_wr_ready", wr_ready, 0);
        chk("idle_we", mem_write_en, 0);
        chk("idle_re", mem_read_en, 0);
        chk("idle_rd_valid", rd_valid, 0);
        if (cmd_valid) begin
          acc_cyc = cyc_n; first_rv = -1; max_out = 0;
          if (cmd_len == 0) done_exp = 1;
          else if (cmd_write) begin
            m_mode = 1; w_addr = int'(cmd_addr); w_len = int'(cmd_len); w_idx = 0;
          end else begin
            m_mode = 2; r_addr = int'(cmd_addr); r_len = int'(cmd_len);
            r_issued = 0; r_popped = 0; last_issue = 0;
            exp_rdata.delete();
            for (int k = 0; k < r_len; k++) exp_rdata.push_back(refmem[(int'(cmd_addr) + k) % DEPTH]);
          end
        end
      end else if (m_mode == 1) begin
        chk("wr_ready", wr_ready, 1);
        chk("wr_we", mem_write_en, wr_valid);
        chk("wr_re", mem_read_en, 0);
        chk("wr_rd_valid", rd_valid, 0);
        if (wr_valid) begin
          chk("wr_addr", mem_addr, w_addr);
          chk("wr_data", mem_data_in, wbuf[w_idx]);
          refmem[w_addr] = wbuf[w_idx];
          wlog_a.push_back(int'(mem_addr));
          wlog_c.push_back(cyc_n);
          w_addr = (w_addr + 1) % DEPTH;
          w_idx++;
          if (w_idx == w_len) begin m_mode = 0; done_exp = 1; end
        end
      end else begin
        outst = r_issued - r_popped;
        if (rd_valid && first_rv < 0) first_rv = cyc_n;
        chk("rd_wr_ready", wr_ready, 0);
        chk("rd_we", mem_write_en, 0);
        chk("rd_valid", rd_valid, outst - int'(last_issue) > 0);
        chk("rd_en", mem_read_en, r_issued < r_len && outst - int'(pop) < 2);
        if (mem_read_en) begin
          chk("rd_addr", mem_addr, r_addr);
          r_addr = (r_addr + 1) % DEPTH;
          r_issued++;
        end
        last_issue = mem_read_en;
        if (pop) begin
          if (exp_rdata.size() == 0) chk("rd_extra_word", 1, 0);
          else chk("rd_data", rd_data, exp_rdata.pop_front());
          rlog_d.push_back(int'(rd_data));
          rlog_c.push_back(cyc_n);
          r_popped++;
          if (r_popped == r_len) begin m_mode = 0; done_exp = 1; end
        end
        if (r_issued - r_popped > max_out) max_out = r_issued - r_popped;
        chk("outstanding_le2", r_issued - r_popped <= 2, 1);
      end
    end
  end

  task automatic issue_cmd(input bit w, input int a, input int n);
    int i = 0;
    while (m_mode != 0 && i < 500) begin @(posedge clk); #1; i++; end
    chk("idle_timeout", i < 500, 1);
    cmd_valid = 1; cmd_write = w; cmd_addr = AW'(a); cmd_len = LEN_W'(n);
    wr_valid = 1; wr_data = WIDTH'($urandom);
    @(posedge clk); #1;
    cmd_valid = 0; wr_valid = 0;
  endtask

  task automatic write_burst(input int a, input int n, input logic [3:0] pat, input bit fixed);
    int k = 0;
    for (int i = 0; i < n; i++) wbuf[i] = fixed ? WIDTH'(8'hA0 + i) : WIDTH'($urandom);
    issue_cmd(1, a, n);
    for (int s = 0; k < n; s++) begin
      wr_valid = pat[s % 4]; wr_data = wbuf[k]; cmd_valid = $urandom_range(0, 3) == 0;
      @(posedge clk); #1;
      if (wr_valid) k++;
    end
    wr_valid = 0; cmd_valid = 0;
  endtask

  task automatic read_burst(input int a, input int n, input int mode);
    int s = 0;
    logic [3:0] p = 4'b1001;
    issue_cmd(0, a, n);
    while (m_mode != 0 && s < 400) begin
      rd_ready = mode == 0 ? 1'b1 : mode == 1 ? p[s % 4] : 1'($urandom);
      cmd_valid = $urandom_range(0, 3) == 0; wr_valid = 1'($urandom); wr_data = WIDTH'($urandom);
      @(posedge clk); #1; s++;
    end
    cmd_valid = 0; wr_valid = 0;
    chk("rd_timeout", s < 400, 1);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, d0, e0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    write_burst(0, 16, 4'hF, 0);
    // wrapping write then read-back
    b = wlog_a.size();
    write_burst(14, 4, 4'hF, 1);
    for (int i = 0; i < 4; i++) chk("t1_waddr", wlog_a[b + i], (14 + i) % 16);
    for (int i = 1; i < 4; i++) chk("t1_wcons", wlog_c[b + i] - wlog_c[b + i - 1], 1);
    b = rlog_d.size();
    read_burst(14, 4, 0);
    for (int i = 0; i < 4; i++) chk("t1_rdata", rlog_d[b + i], 8'hA0 + i);
    // full-depth streaming read
    settle();
    d0 = dn_cnt; b = rlog_d.size();
    read_burst(0, 16, 0);
    chk("t2_first_valid", first_rv - acc_cyc, 3);
    chk("t2_count", rlog_d.size() - b, 16);
    chk("t2_span", rlog_c[b + 15] - rlog_c[b], 15);
    settle();
    chk("t2_done_once", dn_cnt - d0, 1);
    // backpressure
    b = rlog_d.size();
    read_burst(2, 6, 1);
    chk("t3_count", rlog_d.size() - b, 6);
    chk("t3_max_out", max_out, 2);
    // zero-length commands
    settle();
    d0 = dn_cnt; e0 = en_cnt;
    write_burst(3, 0, 4'hF, 0);
    read_burst(3, 0, 0);
    settle();
    chk("t4_done", dn_cnt - d0, 2);
    chk("t4_no_access", en_cnt - e0, 0);
    // write-data gaps
    b = wlog_a.size();
    write_burst(5, 4, 4'b1101, 0);
    for (int i = 0; i < 4; i++) chk("t6_waddr", wlog_a[b + i], 5 + i);
    chk("t6_gap", wlog_c[b + 1] - wlog_c[b], 2);
    chk("t6_gap2", wlog_c[b + 2] - wlog_c[b + 1], 1);
    // reset with a full read buffer
    settle();
    rd_ready = 0;
    issue_cmd(0, 7, 8);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_full_valid", rd_valid, 1);
    chk("t5_full_no_issue", mem_read_en, 0);
    d0 = dn_cnt;
    rst_n = 0;
    #1;
    chk("t5_rst_rd_valid", rd_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cmd_ready", cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    read_burst(7, 8, 0);
    settle();
    chk("t5_done_after", dn_cnt - d0, 1);
    // random traffic
    repeat (40) begin
      if ($urandom_range(0, 1) == 1)
        write_burst($urandom_range(0, 15), $urandom_range(0, 31), 4'($urandom_range(1, 15)), 0);
      else
        read_burst($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 2));
    end
    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Burst initiator for the flip-flop storage unit: accepts a read or write burst command over a valid/ready handshake and drives the storage unit's addr/data_in/write_en/read_en port, one word per cycle with incrementing, wrapping addresses. Write data arrives on a valid/ready stream, and read data leaves on a valid/ready stream. A 2-entry buffer absorbs the storage unit's 1-cycle registered read latency under backpressure. Sits between a DMA/CPU-side client and one storage_unit instance.

## Interface
- WIDTH, 8, word width; must match the storage unit
- DEPTH, 16, storage locations; AW = $clog2(DEPTH)
- LEN_W, $clog2(DEPTH)+1, burst length field width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted; high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AW  start address
- cmd_len  in  LEN_W  words in burst; 0 is legal
- wr_valid / wr_ready  in / out  1  write-data handshake
- wr_data  in  WIDTH  write word
- rd_valid / rd_ready  out / in  1  read-data handshake
- rd_data  out  WIDTH  read word
- mem_addr  out  AW  to storage unit addr
- mem_data_in  out  WIDTH  to storage unit data_in (= wr_data)
- mem_write_en / mem_read_en  out  1  to storage unit enables
- mem_data_out  in  WIDTH  from storage unit data_out
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at burst completion

## Operation
- States: IDLE, WR, RD, RD_DRAIN.
- IDLE: cmd_ready = 1. On cmd_valid, latch addr into cur_addr and len into remain.
  - Go to WR or RD.
  - If len = 0, stay in IDLE and pulse done next cycle; no memory access.
- WR:
  - wr_ready = 1.
  - mem_write_en = wr_valid, mem_addr = cur_addr, mem_data_in = wr_data, all combinational.
  - Each accepted word: cur_addr increments, remain decrements.
  - On the last accepted word, go to IDLE and pulse done in the following cycle.
- RD, issuing reads:
  - mem_read_en = 1 in a cycle iff remain > 0 and (occ + pend − pop) < 2.
  - occ = buffer occupancy; pend = read issued last cycle; pop = rd_valid && rd_ready.
  - Each issue: cur_addr increments, remain decrements.
  - pend is a 1-bit register set by an issue. While pend = 1, mem_data_out is pushed into the buffer at the end of that cycle.
  - After the last issue, go to RD_DRAIN.
- RD_DRAIN:
  - Wait until pend = 0 and the buffer is empty.
  - done pulses in the cycle after the final word's pop; the FSM enters IDLE at the same edge.
- Address arithmetic: cur_addr increments modulo DEPTH (DEPTH−1 → 0). Lengths > DEPTH wrap and revisit locations.
- rd_valid = occ > 0; rd_data = buffer head. The buffer is FIFO-ordered, and push and pop can happen in the same cycle.
- No pop in WR or IDLE can occur (buffer empty).

## Timing
- Reset values:
  - cmd_ready = 1.
  - All other outputs 0: wr_ready, rd_valid, rd_data, mem_addr, mem_data_in, mem_write_en, mem_read_en, busy, done.
  - Buffer flushed, pend = 0, state = IDLE.
- Reset mid-burst abandons the burst: no done pulse, buffered read data discarded.
- Write latency: a word accepted in cycle t is written to memory at the end of cycle t.
- Read latency, with rd_ready held high:
  - First mem_read_en is high in the cycle after command acceptance.
  - rd_valid rises 2 cycles after that read issue.
  - Sustained throughput is 1 word/cycle.
- Backpressure: with rd_ready low, at most 2 reads are outstanding (occ + pend ≤ 2). No data is lost or overwritten.
- cmd_valid outside IDLE is ignored (cmd_ready = 0).
- wr_valid outside WR is ignored.

## Structure
- Package mem_burst_pkg: state enum typedef (IDLE, WR, RD, RD_DRAIN) and localparam RD_BUF_DEPTH = 2.
- Sub-module rd_skid_fifo: 2-entry, WIDTH-wide FIFO with push/pop/occ and asynchronous reset.
- Top level contains the FSM, cur_addr/remain counters, pend flag, and credit logic.

## Test plan
- Write burst addr=14, len=4, data A0..A3, wr_valid always high → mem writes at addresses 14, 15, 0, 1 on consecutive cycles; one done pulse; a subsequent read of addr=14, len=4 returns A0, A1, A2, A3 in order.
- Read burst len=16, rd_ready high → 16 words on consecutive cycles; first rd_valid 3 cycles after the cmd handshake edge; done pulses once.
- Read burst len=6 with rd_ready toggling 1,0,0,1… → correct order; occ + pend never exceeds 2; no duplicate or missing words.
- cmd_len = 0 for both write and read → no mem_write_en/mem_read_en; done pulses the cycle after acceptance; busy stays 0.
- Assert rst_n low mid read burst with buffer full → all outputs reach reset values immediately; no done pulse; after release, a new burst completes normally.
- Write burst with wr_valid gaps (1,0,1,1) → mem_write_en only on valid cycles; addresses advance only on accepted words.
